// File: rtl/crtc_host_bus_if.sv
// Request/response handshake plus MC6845 register-port pins for crtc_host_bus.
// Latency: none; this is a bundle of wires.
// Backpressure: REQ_READY from the slave gates REQ_VALID from the master.
interface crtc_host_bus_if;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic       REQ_RW;
  logic [4:0] REQ_ADDR;
  logic [7:0] REQ_DATA;
  logic       RSP_VALID;
  logic [7:0] RSP_DATA;
  logic       BUSY;
  logic       CSn;
  logic       E;
  logic       RS;
  logic       RW;
  logic [7:0] D_OUT;
  logic       D_OE;
  logic [7:0] D_IN;

  // Bus initiator side: takes requests, drives the CRTC pins.
  modport slave (
    input  REQ_VALID, REQ_RW, REQ_ADDR, REQ_DATA, D_IN,
    output REQ_READY, RSP_VALID, RSP_DATA, BUSY,
    output CSn, E, RS, RW, D_OUT, D_OE
  );

  // Requester / CRTC side.
  modport master (
    output REQ_VALID, REQ_RW, REQ_ADDR, REQ_DATA, D_IN,
    input  REQ_READY, RSP_VALID, RSP_DATA, BUSY,
    input  CSn, E, RS, RW, D_OUT, D_OE
  );
endinterface

// File: rtl/crtc_host_bus.sv
// Turns single register read/write requests into two-phase 6800-style MC6845 accesses.
// Latency: 2(2*E_HALF+1) cycles per request, 2*E_HALF+1 when the address phase is skipped.
// Backpressure: REQ_READY only in IDLE; no queueing, REQ_VALID while busy waits.
module crtc_host_bus #(
  parameter int unsigned E_HALF    = 2,
  parameter bit          SKIP_ADDR = 1'b1
) (
  input logic            CLK,
  input logic            RST,
  crtc_host_bus_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, A_SETUP, A_HIGH, A_HOLD, D_SETUP, D_HIGH, D_HOLD
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(E_HALF - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rw_q, rw_d;
  logic [4:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [4:0] last_addr_q, last_addr_d;
  logic       last_vld_q, last_vld_d;

  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       csn_q, csn_d;
  logic       e_q, e_d;
  logic       rs_q, rs_d;
  logic       rw_out_q, rw_out_d;
  logic       d_oe_q, d_oe_d;
  logic [7:0] d_out_q, d_out_d;

  logic       a_phase, d_phase;

  // Sequencer: accept, time SETUP/HIGH with the down-counter, capture read data.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    data_d      = data_q;
    last_addr_d = last_addr_q;
    last_vld_d  = last_vld_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (bus.REQ_VALID && ready_q) begin
          rw_d   = bus.REQ_RW;
          addr_d = bus.REQ_ADDR;
          data_d = bus.REQ_DATA;
          cnt_d  = CNT_LOAD;
          if (SKIP_ADDR && last_vld_q && (bus.REQ_ADDR == last_addr_q)) state_d = D_SETUP;
          else                                                          state_d = A_SETUP;
        end
      end
      A_SETUP, A_HIGH, D_SETUP: begin
        if (cnt_q == 4'd0) begin
          cnt_d = CNT_LOAD;
          case (state_q)
            A_SETUP: state_d = A_HIGH;
            A_HIGH:  state_d = A_HOLD;
            default: state_d = D_HIGH;
          endcase
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      A_HOLD: begin
        last_addr_d = addr_q;
        last_vld_d  = 1'b1;
        cnt_d       = CNT_LOAD;
        state_d     = D_SETUP;
      end
      D_HIGH: begin
        if (cnt_q == 4'd0) begin
          state_d = D_HOLD;
          if (rw_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = bus.D_IN;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      D_HOLD:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin values for the coming cycle, decoded from the next state so every pin is a flop.
  always_comb begin
    a_phase  = (state_d == A_SETUP) || (state_d == A_HIGH) || (state_d == A_HOLD);
    d_phase  = (state_d == D_SETUP) || (state_d == D_HIGH) || (state_d == D_HOLD);
    ready_d  = (state_d == IDLE);
    busy_d   = !ready_d;
    csn_d    = (state_d == IDLE);
    e_d      = (state_d == A_HIGH) || (state_d == D_HIGH);
    rs_d     = d_phase;
    rw_out_d = d_phase ? rw_d : !a_phase;
    d_oe_d   = a_phase || (d_phase && !rw_d);
    d_out_d  = 8'h00;
    if (a_phase)              d_out_d = {3'b000, addr_d};
    else if (d_phase && !rw_d) d_out_d = data_d;
  end

  // State and registered pins; reset drops E at once and abandons any partial access.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rw_q        <= 1'b0;
      addr_q      <= 5'd0;
      data_q      <= 8'h00;
      last_addr_q <= 5'd0;
      last_vld_q  <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      csn_q       <= 1'b1;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      rw_out_q    <= 1'b1;
      d_oe_q      <= 1'b0;
      d_out_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      last_addr_q <= last_addr_d;
      last_vld_q  <= last_vld_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      csn_q       <= csn_d;
      e_q         <= e_d;
      rs_q        <= rs_d;
      rw_out_q    <= rw_out_d;
      d_oe_q      <= d_oe_d;
      d_out_q     <= d_out_d;
    end
  end

  assign bus.REQ_READY = ready_q;
  assign bus.BUSY      = busy_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_DATA  = rsp_data_q;
  assign bus.CSn       = csn_q;
  assign bus.E         = e_q;
  assign bus.RS        = rs_q;
  assign bus.RW        = rw_out_q;
  assign bus.D_OE      = d_oe_q;
  assign bus.D_OUT     = d_out_q;

endmodule

// File: tb/tb_crtc_host_bus.sv
// Bench for crtc_host_bus: three configurations share stimulus, one is observed at a time.
// A CRTC register model answers reads; expected E pulses and responses go through queues.
// Tasks wait with cycle budgets so a stuck design still reaches the summary line.
module tb_crtc_host_bus;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sel = 2'd0;
  logic       req_valid = 1'b0;
  logic       req_rw = 1'b0;
  logic [4:0] req_addr = 5'd0;
  logic [7:0] req_data = 8'h00;
  logic [7:0] crtc_din;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  crtc_host_bus_if if0 ();
  crtc_host_bus_if if1 ();
  crtc_host_bus_if if2 ();

  assign if0.REQ_VALID = req_valid && (sel == 2'd0);
  assign if1.REQ_VALID = req_valid && (sel == 2'd1);
  assign if2.REQ_VALID = req_valid && (sel == 2'd2);
  assign if0.REQ_RW = req_rw;     assign if1.REQ_RW = req_rw;     assign if2.REQ_RW = req_rw;
  assign if0.REQ_ADDR = req_addr; assign if1.REQ_ADDR = req_addr; assign if2.REQ_ADDR = req_addr;
  assign if0.REQ_DATA = req_data; assign if1.REQ_DATA = req_data; assign if2.REQ_DATA = req_data;
  assign if0.D_IN = crtc_din;     assign if1.D_IN = crtc_din;     assign if2.D_IN = crtc_din;

  crtc_host_bus #(.E_HALF(2), .SKIP_ADDR(1'b1)) u_dut0 (.CLK(clk), .RST(rst), .bus(if0.slave));
  crtc_host_bus #(.E_HALF(2), .SKIP_ADDR(1'b0)) u_dut1 (.CLK(clk), .RST(rst), .bus(if1.slave));
  crtc_host_bus #(.E_HALF(1), .SKIP_ADDR(1'b1)) u_dut2 (.CLK(clk), .RST(rst), .bus(if2.slave));

  // Observed outputs of the selected instance
  logic [23:0] o0, o1, o2, mo;
  logic m_ready, m_busy, m_rsp_valid, m_csn, m_e, m_rs, m_rw, m_d_oe;
  logic [7:0] m_rsp_data, m_d_out;
  assign o0 = {if0.REQ_READY, if0.BUSY, if0.RSP_VALID, if0.RSP_DATA, if0.CSn, if0.E, if0.RS, if0.RW, if0.D_OE, if0.D_OUT};
  assign o1 = {if1.REQ_READY, if1.BUSY, if1.RSP_VALID, if1.RSP_DATA, if1.CSn, if1.E, if1.RS, if1.RW, if1.D_OE, if1.D_OUT};
  assign o2 = {if2.REQ_READY, if2.BUSY, if2.RSP_VALID, if2.RSP_DATA, if2.CSn, if2.E, if2.RS, if2.RW, if2.D_OE, if2.D_OUT};
  assign mo = (sel == 2'd0) ? o0 : (sel == 2'd1) ? o1 : o2;
  assign {m_ready, m_busy, m_rsp_valid, m_rsp_data, m_csn, m_e, m_rs, m_rw, m_d_oe, m_d_out} = mo;

  // Reset value of the packed observation vector
  localparam logic [23:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};

  // CRTC register model: address register and data registers latched while E is high
  logic [7:0] crtc_reg [32];
  logic [4:0] crtc_ar = 5'd0;
  always @(posedge clk) begin
    if (rst) crtc_reg[14] <= 8'h3A;
    else if (m_e && !m_csn && !m_rw) begin
      if (!m_rs) crtc_ar <= m_d_out[4:0];
      else       crtc_reg[crtc_ar] <= m_d_out;
    end
  end
  assign crtc_din = (!m_csn && m_rs && m_rw) ? crtc_reg[crtc_ar] : 8'hFF;

  // Scoreboards: expected {RS,RW,D_OE,D_OUT-if-driven} per E pulse, expected read data
  logic [10:0] pulse_q[$];
  logic [7:0]  rsp_q[$];

  // Bus monitor, sampled on the falling edge
  logic        e_prev = 1'b0;
  logic        in_pulse = 1'b0;
  int          width = 0;
  logic [10:0] prev_bus = '0, rise_bus = '0, cur_bus;
  int          n_sel;
  always @(negedge clk) begin
    cur_bus = {m_rs, m_rw, m_d_oe, m_d_oe ? m_d_out : 8'h00};
    n_sel = (sel == 2'd2) ? 1 : 2;
    if (rst) begin
      in_pulse = 1'b0;
    end else begin
      if (m_e && !e_prev) begin
        checks++;
        if (pulse_q.size() == 0) begin
          errors++; $display("FAIL unexpected_e_pulse bus=%h", cur_bus);
        end else begin
          logic [10:0] exp_bus;
          exp_bus = pulse_q.pop_front();
          if (cur_bus !== exp_bus || m_csn !== 1'b0) begin
            errors++; $display("FAIL pulse_fields got=%h csn=%b want=%h csn=0", cur_bus, m_csn, exp_bus);
          end
        end
        checks++;
        if (prev_bus !== cur_bus) begin
          errors++; $display("FAIL setup_stable got=%h before E, %h at E rise", prev_bus, cur_bus);
        end
        rise_bus = cur_bus; width = 1; in_pulse = 1'b1;
      end else if (m_e && e_prev) begin
        width++;
        checks++;
        if (cur_bus !== rise_bus) begin
          errors++; $display("FAIL stable_during_e got=%h want=%h", cur_bus, rise_bus);
        end
      end else if (!m_e && e_prev && in_pulse) begin
        checks++;
        if (width != n_sel) begin
          errors++; $display("FAIL e_width got=%0d want=%0d", width, n_sel);
        end
        checks++;
        if (cur_bus !== rise_bus) begin
          errors++; $display("FAIL hold_stable got=%h want=%h", cur_bus, rise_bus);
        end
        in_pulse = 1'b0;
      end
      if (m_rsp_valid) begin
        checks++;
        if (rsp_q.size() == 0) begin
          errors++; $display("FAIL unexpected_rsp data=%h", m_rsp_data);
        end else begin
          logic [7:0] exp_d;
          exp_d = rsp_q.pop_front();
          if (m_rsp_data !== exp_d) begin
            errors++; $display("FAIL rsp_data got=%h want=%h", m_rsp_data, exp_d);
          end
        end
      end
    end
    prev_bus = cur_bus;
    e_prev = m_e;
  end

  task automatic apply_reset();
    req_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    pulse_q.delete();
    rsp_q.delete();
  endtask

  // Push expectations, present the request, return one cycle after the accept edge
  task automatic start_req(input logic rw, input logic [4:0] addr, input logic [7:0] data,
                           input logic [7:0] exp_rd, input bit skip, input bit keep);
    int n;
    if (!skip) pulse_q.push_back({1'b0, 1'b0, 1'b1, 3'b000, addr});
    pulse_q.push_back({1'b1, rw, ~rw, rw ? 8'h00 : data});
    if (rw) rsp_q.push_back(exp_rd);
    req_rw = rw; req_addr = addr; req_data = data; req_valid = 1'b1;
    n = 0;
    while (!m_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin
      checks++; errors++; $display("FAIL accept_timeout ready=%b want=1", m_ready);
    end
    @(posedge clk); #1;
    if (!keep) req_valid = 1'b0;
  endtask

  // Count busy cycles (accept edge = cycle 0) until REQ_READY returns
  task automatic finish_req(output int busy, output int rsp_cyc, output int rsp_n);
    int c;
    c = 1; rsp_cyc = -1; rsp_n = 0;
    while (c < 200) begin
      if (m_rsp_valid) begin rsp_n++; rsp_cyc = c; end
      if (m_ready) break;
      @(posedge clk); #1; c++;
    end
    if (c >= 200) begin
      checks++; errors++; $display("FAIL ready_timeout ready=%b want=1", m_ready);
    end
    busy = c - 1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s); #1;
      checks++;
      if (mo !== RESET_VEC) begin
        errors++; $display("FAIL reset_values dut%0d got=%h want=%h", s, mo, RESET_VEC);
      end
    end
    sel = 2'd0;
  endtask

  task automatic test_write();
    int b, rc, rn;
    sel = 2'd0; apply_reset();
    start_req(1'b0, 5'd0, 8'h5E, 8'h00, 1'b0, 1'b0);
    checks++;
    if (m_busy !== 1'b1 || m_ready !== 1'b0) begin
      errors++; $display("FAIL write_busy busy=%b ready=%b want busy=1 ready=0", m_busy, m_ready);
    end
    finish_req(b, rc, rn);
    checks++; if (b != 10) begin errors++; $display("FAIL write_len got=%0d want=10", b); end
    checks++; if (rn != 0) begin errors++; $display("FAIL write_rsp got=%0d pulses want=0", rn); end
    checks++;
    if (pulse_q.size() != 0) begin errors++; $display("FAIL write_pulses left=%0d want=0", pulse_q.size()); end
  endtask

  task automatic test_read();
    int b, rc, rn;
    sel = 2'd0; apply_reset();
    start_req(1'b1, 5'd14, 8'h00, 8'h3A, 1'b0, 1'b0);
    finish_req(b, rc, rn);
    checks++; if (b != 10) begin errors++; $display("FAIL read_len got=%0d want=10", b); end
    checks++;
    if (rn != 1 || rc != 10) begin errors++; $display("FAIL read_rsp_cycle got=%0d x%0d want=10 x1", rc, rn); end
    checks++;
    if (m_rsp_data !== 8'h3A) begin errors++; $display("FAIL read_rsp_held got=%h want=3a", m_rsp_data); end
    checks++;
    if (pulse_q.size() != 0 || rsp_q.size() != 0) begin
      errors++; $display("FAIL read_sb left=%0d/%0d want=0/0", pulse_q.size(), rsp_q.size());
    end
  endtask

  task automatic test_skip();
    int b, rc, rn;
    sel = 2'd0; apply_reset();
    start_req(1'b0, 5'd15, 8'hAD, 8'h00, 1'b0, 1'b0);
    finish_req(b, rc, rn);
    checks++; if (b != 10) begin errors++; $display("FAIL skip_wr_len got=%0d want=10", b); end
    start_req(1'b1, 5'd15, 8'h00, 8'hAD, 1'b1, 1'b0);
    finish_req(b, rc, rn);
    checks++; if (b != 5) begin errors++; $display("FAIL skip_rd_len got=%0d want=5", b); end
    checks++;
    if (rn != 1 || rc != 5) begin errors++; $display("FAIL skip_rd_cycle got=%0d x%0d want=5 x1", rc, rn); end
    // out-of-range register numbers still update the remembered address
    start_req(1'b0, 5'd20, 8'h99, 8'h00, 1'b0, 1'b0);
    finish_req(b, rc, rn);
    start_req(1'b0, 5'd20, 8'h55, 8'h00, 1'b1, 1'b0);
    finish_req(b, rc, rn);
    checks++; if (b != 5) begin errors++; $display("FAIL skip_r20_len got=%0d want=5", b); end
    // SKIP_ADDR=0: address phase always present
    sel = 2'd1; apply_reset();
    start_req(1'b0, 5'd15, 8'hAD, 8'h00, 1'b0, 1'b0);
    finish_req(b, rc, rn);
    start_req(1'b1, 5'd15, 8'h00, 8'hAD, 1'b0, 1'b0);
    finish_req(b, rc, rn);
    checks++; if (b != 10) begin errors++; $display("FAIL noskip_rd_len got=%0d want=10", b); end
    checks++;
    if (rn != 1 || rc != 10) begin errors++; $display("FAIL noskip_rd_cycle got=%0d x%0d want=10 x1", rc, rn); end
    checks++;
    if (pulse_q.size() != 0 || rsp_q.size() != 0) begin
      errors++; $display("FAIL skip_sb left=%0d/%0d want=0/0", pulse_q.size(), rsp_q.size());
    end
    sel = 2'd0;
  endtask

  task automatic test_back_to_back();
    int b, rc, rn;
    sel = 2'd0; apply_reset();
    start_req(1'b0, 5'd1, 8'h4C, 8'h00, 1'b0, 1'b1);
    req_addr = 5'd2; req_data = 8'h4E;
    finish_req(b, rc, rn);
    checks++; if (b != 10) begin errors++; $display("FAIL b2b_first_len got=%0d want=10", b); end
    checks++;
    if (m_csn !== 1'b1 || m_e !== 1'b0) begin errors++; $display("FAIL b2b_idle csn=%b e=%b want csn=1 e=0", m_csn, m_e); end
    start_req(1'b0, 5'd2, 8'h4E, 8'h00, 1'b0, 1'b0);
    checks++;
    if (m_ready !== 1'b0 || m_csn !== 1'b0) begin
      errors++; $display("FAIL b2b_one_idle ready=%b csn=%b want ready=0 csn=0", m_ready, m_csn);
    end
    finish_req(b, rc, rn);
    checks++; if (b != 10) begin errors++; $display("FAIL b2b_second_len got=%0d want=10", b); end
    checks++;
    if (pulse_q.size() != 0) begin errors++; $display("FAIL b2b_pulses left=%0d want=0", pulse_q.size()); end
  endtask

  task automatic test_rst_abort();
    int b, rc, rn, n;
    sel = 2'd0; apply_reset();
    start_req(1'b1, 5'd14, 8'h00, 8'h3A, 1'b0, 1'b0);
    finish_req(b, rc, rn);
    start_req(1'b1, 5'd5, 8'h00, 8'h00, 1'b0, 1'b0);
    n = 0;
    while (!m_e && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (m_e !== 1'b1 || m_rs !== 1'b0) begin errors++; $display("FAIL abort_a_high e=%b rs=%b want e=1 rs=0", m_e, m_rs); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (m_e !== 1'b0 || m_csn !== 1'b1 || m_ready !== 1'b1 || m_rsp_valid !== 1'b0 || m_busy !== 1'b0) begin
      errors++; $display("FAIL abort_state e=%b csn=%b ready=%b rsp=%b busy=%b want 0 1 1 0 0", m_e, m_csn, m_ready, m_rsp_valid, m_busy);
    end
    rst = 1'b0;
    pulse_q.delete();
    rsp_q.delete();
    start_req(1'b1, 5'd14, 8'h00, 8'h3A, 1'b0, 1'b0);
    finish_req(b, rc, rn);
    checks++; if (b != 10) begin errors++; $display("FAIL abort_noskip_len got=%0d want=10", b); end
    checks++;
    if (rn != 1 || rc != 10) begin errors++; $display("FAIL abort_rd_cycle got=%0d x%0d want=10 x1", rc, rn); end
  endtask

  task automatic test_e_half1();
    int b, rc, rn;
    sel = 2'd2; apply_reset();
    start_req(1'b0, 5'd9, 8'h07, 8'h00, 1'b0, 1'b0);
    finish_req(b, rc, rn);
    checks++; if (b != 6) begin errors++; $display("FAIL ehalf1_len got=%0d want=6", b); end
    checks++;
    if (pulse_q.size() != 0) begin errors++; $display("FAIL ehalf1_pulses left=%0d want=0", pulse_q.size()); end
    @(negedge clk); #1;
    sel = 2'd0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_skip();
    test_back_to_back();
    test_rst_abort();
    test_e_half1();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/crtc_host_bus.md
# crtc_host_bus

Host-side bus initiator for the MC6845 CRTC register port. It accepts single register read/write requests over a valid/ready handshake. Each request is turned into the 6800-style two-phase CRTC access: an address-register write with RS=0, then a data access with RS=1. The block drives CSn/E/RS/RW and the split data bus in place of a CPU. It sits between the video controller's configuration logic (init sequencer, cursor updater) and the CRTC instance.

## Interface

Parameters:
- E_HALF, 2, CLK cycles per E setup and per E high interval; legal range 1..15.
- SKIP_ADDR, 1, when 1, omit the address phase if REQ_ADDR equals the last address latched into the CRTC.

Ports:
- CLK  in  1  system clock; the only clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  block can accept a request (IDLE only).
- REQ_RW  in  1  1 = read, 0 = write.
- REQ_ADDR  in  5  CRTC register number R0..R17.
- REQ_DATA  in  8  write data; ignored for reads.
- RSP_VALID  out  1  one-cycle pulse, read data valid.
- RSP_DATA  out  8  read data; held until the next read completes.
- BUSY  out  1  transaction in progress (= !REQ_READY outside reset).
- CSn  out  1  CRTC chip select, active low.
- E  out  1  CRTC bus enable strobe.
- RS  out  1  0 = address register, 1 = selected data register.
- RW  out  1  0 = write, 1 = read.
- D_OUT  out  8  data driven onto the CRTC bus.
- D_OE  out  1  1 = D_OUT drives the bus; top level builds the tristate.
- D_IN  in  8  bus value seen from the CRTC.

## Operation

- Reset values: REQ_READY=1, BUSY=0, RSP_VALID=0, RSP_DATA=0x00, CSn=1, E=0, RS=0, RW=1, D_OE=0, D_OUT=0x00. The last-address-valid flag is cleared.
- States: IDLE, A_SETUP, A_HIGH, A_HOLD, D_SETUP, D_HIGH, D_HOLD. A down-counter times the SETUP and HIGH states.
- IDLE:
  - REQ_READY=1, CSn=1.
  - On REQ_VALID&REQ_READY, latch RW/ADDR/DATA.
  - If SKIP_ADDR and last-address-valid and REQ_ADDR==last_addr, go to D_SETUP. Otherwise go to A_SETUP.
- Address phase (A_*):
  - CSn=0, RS=0, RW=0, D_OE=1, D_OUT={3'b000,addr}.
  - E=1 only in A_HIGH.
  - At A_HOLD exit, set last_addr=addr and last-address-valid=1.
- Data phase (D_*):
  - CSn=0, RS=1, RW=latched RW.
  - Write: D_OE=1, D_OUT=data. Read: D_OE=0.
  - E=1 only in D_HIGH.
- Read capture: D_IN is sampled on the clock edge that ends the final D_HIGH cycle. It is loaded into RSP_DATA, and RSP_VALID=1 for exactly the D_HOLD cycle.
- After D_HOLD, return to IDLE. CSn=1, D_OE=0 and RW=1 in the same cycle.
- No requests are queued; REQ_VALID while BUSY is ignored until REQ_READY=1.
- Addresses 18..31 are issued unmodified; the CRTC ignores them. last_addr still updates.
- RST in any state: the next edge forces all reset values. E falls immediately; a partial access is abandoned with no RSP_VALID.

## Timing

- All outputs are registered and change only on rising CLK edges.
- Let N = E_HALF. Phase lengths:
  - SETUP = N cycles.
  - HIGH = N cycles.
  - HOLD = 1 cycle.
  - One phase = 2N+1 cycles.
- Full transaction: 2(2N+1) cycles after the accept edge. With N=2 that is 10 cycles; REQ_READY is high again on cycle 11.
- Skipped-address transaction: 2N+1 cycles (5 with N=2).
- RS, RW and D_OUT are stable for N cycles before E rises and 1 cycle after E falls. They never change while E=1.
- Read latency, with N=2 and the accept edge as cycle 0: RSP_VALID in cycle 10, or cycle 5 when the address phase is skipped.
- Back-to-back: a request held valid is accepted on the first IDLE cycle. There is exactly 1 IDLE cycle with CSn=1 between transactions.

## Test plan

- Write R0=0x5E, N=2:
  - One E pulse with RS=0, D=0x00, then one with RS=1, RW=0, D=0x5E.
  - REQ_READY low for 10 cycles.
- Read R14 (CRTC model holds 0x3A, N=2):
  - RS=1, RW=1, D_OE=0 in the data phase.
  - RSP_VALID pulses once, in cycle 10, with RSP_DATA=0x3A.
- SKIP_ADDR: write R15=0xAD, then read R15:
  - The read has no RS=0 phase and RSP_VALID arrives in cycle 5.
  - With SKIP_ADDR=0, the address phase is present.
- Back-to-back writes R1=0x4C, R2=0x4E with REQ_VALID held:
  - Both complete, 1 IDLE cycle between them, no overlap of E pulses.
- RST asserted during A_HIGH:
  - The next cycle shows E=0, CSn=1, REQ_READY=1 and no RSP_VALID.
  - A following R14 read is not skipped.
- E_HALF=1: write R9=0x07 completes in 6 cycles, with every E high pulse exactly 1 cycle wide.
